// File: rtl/mfp_irq_ctrl.sv
// ---------------------------------------------------------------------------
// mfp_irq_ctrl
// Interrupt priority and acknowledge stage of the MFP. Picks the highest
// eligible pending channel (channel 15 highest), drives the active-low CPU
// interrupt request, runs the interrupt-acknowledge handshake, supplies the
// vector, pulses the pending-bit clear and keeps the in-service register.
//
// Ports
//   clk          system clock, rising edge
//   reset_n      asynchronous active-low reset
//   ipr[15:0]    pending bits
//   imr[15:0]    mask, 1 = channel may request
//   vr_s         software end-of-interrupt mode (isr forced to 0 when low)
//   vr_base[3:0] upper vector nibble
//   isr_wr       one-cycle ISR write strobe
//   isr_wdata    0 bits clear the ISR bit, 1 bits leave it
//   iack         CPU acknowledge level
//   irq_n        registered interrupt request, active low
//   ipr_clr      one-hot one-cycle clear pulse to the pending flip-flops
//   vector       {vr_base, channel}
//   vector_valid vector valid on the bus (drives DTACK)
//   isr          in-service register
//   dbg_state    current FSM state (0 IDLE, 1 ACK, 2 HOLD, 3 NOACK)
//
// Handshake: iack is a level. It is registered once (iack_s) and compared
// against the previous registered sample (iack_d); a rising edge seen on
// the registered pair starts an acknowledge on the following clock, and a
// registered low ends it. vector_valid is high from the ACK cycle until the
// cycle after iack is sampled low.
// ---------------------------------------------------------------------------
module mfp_irq_ctrl (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] ipr,
  input  logic [15:0] imr,
  input  logic        vr_s,
  input  logic [3:0]  vr_base,
  input  logic        isr_wr,
  input  logic [15:0] isr_wdata,
  input  logic        iack,
  output logic        irq_n,
  output logic [15:0] ipr_clr,
  output logic [7:0]  vector,
  output logic        vector_valid,
  output logic [15:0] isr,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACK   = 2'd1,
    HOLD  = 2'd2,
    NOACK = 2'd3
  } state_t;

  state_t      state;
  logic [3:0]  chan;
  logic        iack_s;
  logic        iack_d;
  logic        hist_vld;

  logic [15:0] eligible;
  logic [3:0]  top_req;
  logic [3:0]  top_isr;
  logic        isr_any;
  logic        active;
  logic        iack_rise;
  logic [15:0] isr_next;

  assign eligible  = ipr & imr;
  assign isr_any   = |isr;
  assign active    = (|eligible) && (!isr_any || (top_req > top_isr));
  assign iack_rise = hist_vld && iack_s && !iack_d;
  assign dbg_state = state;

  // Highest set bit wins because later iterations overwrite earlier ones.
  always_comb begin
    top_req = 4'd0;
    top_isr = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (eligible[i]) top_req = i[3:0];
      if (isr[i])      top_isr = i[3:0];
    end
  end

  // Clear-by-write first, then the acknowledge set, so a set in the same
  // cycle as a clearing write leaves the bit set.
  always_comb begin
    isr_next = isr;
    if (!vr_s) begin
      isr_next = 16'h0000;
    end else begin
      if (isr_wr) isr_next = isr & isr_wdata;
      if (state == ACK) isr_next = isr_next | (16'h0001 << chan);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      chan         <= 4'd0;
      iack_s       <= 1'b0;
      iack_d       <= 1'b0;
      hist_vld     <= 1'b0;
      irq_n        <= 1'b1;
      ipr_clr      <= 16'h0000;
      vector       <= 8'h00;
      vector_valid <= 1'b0;
      isr          <= 16'h0000;
    end else begin
      iack_s   <= iack;
      // On the first clock out of reset the history is seeded with the
      // live sample, so an iack already high at release is not an edge.
      iack_d   <= hist_vld ? iack_s : iack;
      hist_vld <= 1'b1;
      isr      <= isr_next;

      case (state)
        IDLE: begin
          ipr_clr <= 16'h0000;
          if (iack_rise) begin
            irq_n <= 1'b1;
            if (active) begin
              chan         <= top_req;
              vector       <= {vr_base, top_req};
              vector_valid <= 1'b1;
              ipr_clr      <= 16'h0001 << top_req;
              state        <= ACK;
            end else begin
              state <= NOACK;
            end
          end else begin
            irq_n <= ~active;
          end
        end
        ACK: begin
          irq_n   <= 1'b1;
          ipr_clr <= 16'h0000;
          state   <= HOLD;
        end
        HOLD: begin
          irq_n   <= 1'b1;
          ipr_clr <= 16'h0000;
          if (!iack_s) begin
            vector_valid <= 1'b0;
            state        <= IDLE;
          end
        end
        NOACK: begin
          irq_n   <= 1'b1;
          ipr_clr <= 16'h0000;
          if (!iack_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mfp_irq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mfp_irq_ctrl
// Directed bench for mfp_irq_ctrl. Inputs are driven and outputs sampled
// 1 ns after each rising edge. Expected acknowledge vectors are queued in
// exp_q and popped as each acknowledge completes.
// ---------------------------------------------------------------------------
module tb_mfp_irq_ctrl;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACK   = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;
  localparam logic [1:0] S_NOACK = 2'd3;

  logic        clk;
  logic        reset_n;
  logic [15:0] ipr;
  logic [15:0] imr;
  logic        vr_s;
  logic [3:0]  vr_base;
  logic        isr_wr;
  logic [15:0] isr_wdata;
  logic        iack;
  logic        irq_n;
  logic [15:0] ipr_clr;
  logic [7:0]  vector;
  logic        vector_valid;
  logic [15:0] isr;
  logic [1:0]  dbg_state;

  int n_checks;
  int n_errors;
  logic [7:0] exp_q[$];

  mfp_irq_ctrl dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .ipr          (ipr),
    .imr          (imr),
    .vr_s         (vr_s),
    .vr_base      (vr_base),
    .isr_wr       (isr_wr),
    .isr_wdata    (isr_wdata),
    .iack         (iack),
    .irq_n        (irq_n),
    .ipr_clr      (ipr_clr),
    .vector       (vector),
    .vector_valid (vector_valid),
    .isr          (isr),
    .dbg_state    (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Full acknowledge of the channel whose vector is at the head of exp_q.
  task automatic do_ack(input string tag, input logic [15:0] exp_clr);
    logic [7:0] exp_vec;
    exp_vec = exp_q.pop_front();
    iack = 1'b1;
    step();
    check({tag, " pre-ack valid"}, {31'd0, vector_valid}, 32'd0);
    step();
    check({tag, " ack state"}, {30'd0, dbg_state}, {30'd0, S_ACK});
    check({tag, " vector"}, {24'd0, vector}, {24'd0, exp_vec});
    check({tag, " valid"}, {31'd0, vector_valid}, 32'd1);
    check({tag, " ipr_clr"}, {16'd0, ipr_clr}, {16'd0, exp_clr});
    check({tag, " irq_n in ack"}, {31'd0, irq_n}, 32'd1);
    ipr = ipr & ~exp_clr;  // pending flip-flop reacts to the clear pulse
    step();
    check({tag, " hold state"}, {30'd0, dbg_state}, {30'd0, S_HOLD});
    check({tag, " ipr_clr one cycle"}, {16'd0, ipr_clr}, 32'd0);
    check({tag, " hold valid"}, {31'd0, vector_valid}, 32'd1);
    check({tag, " hold vector"}, {24'd0, vector}, {24'd0, exp_vec});
    iack = 1'b0;
    step();
    check({tag, " valid before drop"}, {31'd0, vector_valid}, 32'd1);
    step();
    check({tag, " valid dropped"}, {31'd0, vector_valid}, 32'd0);
    check({tag, " back to idle"}, {30'd0, dbg_state}, {30'd0, S_IDLE});
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    reset_n   = 1'b0;
    ipr       = 16'h0000;
    imr       = 16'hFFFF;
    vr_s      = 1'b0;
    vr_base   = 4'h4;
    isr_wr    = 1'b0;
    isr_wdata = 16'hFFFF;
    iack      = 1'b0;
    step();
    step();
    check("rst irq_n", {31'd0, irq_n}, 32'd1);
    check("rst ipr_clr", {16'd0, ipr_clr}, 32'd0);
    check("rst vector", {24'd0, vector}, 32'd0);
    check("rst valid", {31'd0, vector_valid}, 32'd0);
    check("rst isr", {16'd0, isr}, 32'd0);
    check("rst state", {30'd0, dbg_state}, {30'd0, S_IDLE});
    reset_n = 1'b1;
    step();

    // Basic acknowledge of channel 13
    ipr = 16'h2000;
    step();
    check("basic irq_n", {31'd0, irq_n}, 32'd0);
    exp_q.push_back(8'h4D);
    do_ack("basic", 16'h2000);
    check("basic isr", {16'd0, isr}, 32'd0);
    check("basic irq_n after", {31'd0, irq_n}, 32'd1);

    // Priority and mask
    ipr = 16'h8081;
    imr = 16'h7FFF;
    step();
    check("prio irq_n", {31'd0, irq_n}, 32'd0);
    exp_q.push_back(8'h47);
    do_ack("prio7", 16'h0080);
    imr = 16'h0001;
    step();
    exp_q.push_back(8'h40);
    do_ack("prio0", 16'h0001);
    ipr = 16'h8081;
    imr = 16'h0000;
    step();
    step();
    check("masked irq_n", {31'd0, irq_n}, 32'd1);

    // Software end-of-interrupt
    imr  = 16'hFFFF;
    vr_s = 1'b1;
    ipr  = 16'h0020;
    step();
    check("eoi irq_n ch5", {31'd0, irq_n}, 32'd0);
    exp_q.push_back(8'h45);
    do_ack("eoi5", 16'h0020);
    check("eoi isr ch5", {16'd0, isr}, 32'h0020);
    ipr = 16'h0008;
    step();
    step();
    check("eoi lower blocked", {31'd0, irq_n}, 32'd1);
    ipr = 16'h0208;
    step();
    check("eoi higher irq_n", {31'd0, irq_n}, 32'd0);
    exp_q.push_back(8'h49);
    do_ack("eoi9", 16'h0200);
    check("eoi isr nested", {16'd0, isr}, 32'h0220);
    isr_wr    = 1'b1;
    isr_wdata = 16'hFDFF;
    step();
    isr_wr    = 1'b0;
    check("eoi isr write", {16'd0, isr}, 32'h0020);
    step();
    check("eoi ch3 still blocked", {31'd0, irq_n}, 32'd1);

    // Spurious acknowledge: ch3 pending but below in-service ch5
    iack = 1'b1;
    step();
    step();
    check("spur state", {30'd0, dbg_state}, {30'd0, S_NOACK});
    check("spur valid", {31'd0, vector_valid}, 32'd0);
    check("spur ipr_clr", {16'd0, ipr_clr}, 32'd0);
    step();
    check("spur ipr_clr later", {16'd0, ipr_clr}, 32'd0);
    check("spur valid later", {31'd0, vector_valid}, 32'd0);
    iack = 1'b0;
    step();
    step();
    check("spur idle", {30'd0, dbg_state}, {30'd0, S_IDLE});
    check("spur isr kept", {16'd0, isr}, 32'h0020);

    // Set wins over a clearing write in the ACK cycle
    isr_wr    = 1'b1;
    isr_wdata = 16'hFFDF;
    ipr       = 16'h0020;
    step();
    isr_wr = 1'b0;
    check("sim isr cleared", {16'd0, isr}, 32'd0);
    step();
    check("sim irq_n", {31'd0, irq_n}, 32'd0);
    iack = 1'b1;
    step();
    step();
    check("sim vector", {24'd0, vector}, 32'h45);
    isr_wr    = 1'b1;
    isr_wdata = 16'hFFDF;
    ipr       = 16'h0000;
    step();
    isr_wr = 1'b0;
    check("sim set wins", {16'd0, isr}, 32'h0020);
    iack = 1'b0;
    step();
    step();
    check("sim idle", {30'd0, dbg_state}, {30'd0, S_IDLE});
    vr_s = 1'b0;
    step();
    check("vr_s clear isr", {16'd0, isr}, 32'd0);

    // Reset in the middle of HOLD
    vr_s = 1'b1;
    ipr  = 16'h0400;
    step();
    iack = 1'b1;
    step();
    step();
    step();
    check("rh hold valid", {31'd0, vector_valid}, 32'd1);
    check("rh isr before", {16'd0, isr}, 32'h0400);
    reset_n = 1'b0;
    #1;
    check("rh async valid", {31'd0, vector_valid}, 32'd0);
    check("rh async irq_n", {31'd0, irq_n}, 32'd1);
    check("rh async isr", {16'd0, isr}, 32'd0);
    check("rh async state", {30'd0, dbg_state}, {30'd0, S_IDLE});
    step();
    reset_n = 1'b1;
    step();
    check("rh irq_n after release", {31'd0, irq_n}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      check("rh no ack while high", {31'd0, vector_valid}, 32'd0);
    end
    check("rh still idle", {30'd0, dbg_state}, {30'd0, S_IDLE});
    iack = 1'b0;
    step();
    step();
    exp_q.push_back(8'h4A);
    do_ack("rh reack", 16'h0400);
    check("rh isr reack", {16'd0, isr}, 32'h0400);
    check("exp_q drained", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mfp_irq_ctrl.md
# mfp_irq_ctrl

Interrupt priority and acknowledge stage of the MFP, directly downstream of the 16-bit pending-register flip-flops. Takes the 16 pending bits and the mask register, picks the highest-priority eligible channel, drives the CPU interrupt request, and runs the interrupt-acknowledge handshake. On acknowledge it supplies the vector, returns a one-cycle clear pulse to the pending flip-flops, and maintains the in-service register for software end-of-interrupt mode.

## Interface
- No parameters. Channel count is fixed at 16; channel 15 has the highest priority.
- clk  in  1  system clock; all state changes on its rising edge
- reset_n  in  1  asynchronous, active-low reset
- ipr  in  16  pending bits from the pending-register flip-flops
- imr  in  16  interrupt mask; 1 = channel may request
- vr_s  in  1  software end-of-interrupt mode enable (S bit of the vector register)
- vr_base  in  4  upper vector nibble
- isr_wr  in  1  one-cycle write strobe for the in-service register
- isr_wdata  in  16  write data; a 0 bit clears that ISR bit, a 1 bit leaves it unchanged
- iack  in  1  CPU interrupt-acknowledge level, held until the cycle ends
- irq_n  out  1  interrupt request to CPU, active-low, registered
- ipr_clr  out  16  one-hot, one-cycle clear pulse to the pending flip-flop reset inputs
- vector  out  8  acknowledge vector {vr_base, channel}
- vector_valid  out  1  vector on the bus is valid (drives DTACK)
- isr  out  16  in-service register, readable by the CPU

## Operation
- eligible = ipr & imr. top_req = index of the highest set bit of eligible.
- top_isr = index of the highest set bit of isr, or -1 if isr = 0.
- A request is active when eligible != 0 and top_req > top_isr. If vr_s = 0, isr is always 0, so any eligible bit is active.
- FSM states: IDLE, ACK, HOLD, NOACK.
- IDLE: irq_n = ~active. On an iack rising edge (iack = 1 and the previous-cycle iack = 0):
  - active: latch chan = top_req and go to ACK.
  - not active: go to NOACK.
- ACK, exactly one cycle:
  - vector = {vr_base, chan}, vector_valid = 1, ipr_clr = 1 << chan.
  - If vr_s = 1, set isr[chan].
  - Go to HOLD.
- HOLD: vector and vector_valid are held, ipr_clr = 0. Return to IDLE in the first cycle iack = 0; vector_valid drops in that same cycle.
- NOACK: vector_valid stays 0 and no pending bit is cleared (spurious acknowledge; the bus times out). Return to IDLE when iack = 0.
- irq_n is forced to 1 in ACK, HOLD and NOACK.
- ISR update each cycle, applied in this order:
  1. If vr_s = 0: isr <= 0.
  2. Otherwise, if isr_wr: isr <= isr & isr_wdata.
  3. Then the ACK set is applied. A set in the same cycle as a write clearing that bit wins.
- Changes to ipr/imr during ACK/HOLD do not alter the latched chan or vector.

## Timing
- Reset values: irq_n = 1, ipr_clr = 0, vector = 8'h00, vector_valid = 0, isr = 0, state IDLE, iack history = 0.
- Reset asserted mid-handshake returns all outputs to reset values immediately (asynchronously).
- irq_n latency: one clock after the ipr/imr/isr change that makes the request active or inactive.
- iack rising edge sampled at edge k: ACK state, vector_valid = 1, and the ipr_clr pulse all appear after edge k+1.
- The pending bit falls on the following cycle (set/reset flip-flop latency). irq_n is not re-evaluated until IDLE, so a cleared request never produces a stale IRQ.
- iack falling sampled at edge m: vector_valid = 0 after edge m+1, FSM in IDLE.
- A new request may assert irq_n one cycle after that.
- Back-to-back acknowledges are allowed with one idle cycle between them.

## Test plan
- Reset, then ipr = 16'h2000, imr = 16'hFFFF, vr_base = 4'h4, vr_s = 0:
  - irq_n = 0 one cycle later.
  - Pulse iack: vector = 8'h4D and vector_valid = 1 after one cycle; ipr_clr = 16'h2000 for exactly one cycle; isr stays 0.
- Priority and mask: ipr = 16'h8081 with imr = 16'h7FFF → vector low nibble = 7. With imr = 16'h0001 → nibble = 0. With imr = 0 → irq_n stays 1.
- Software EOI, vr_s = 1:
  - Acknowledge ch 5: isr = 16'h0020.
  - Raising ipr[3] → irq_n stays 1. Raising ipr[9] → irq_n = 0; acknowledge gives isr = 16'h0220.
  - isr_wr with isr_wdata = 16'hFDFF → isr = 16'h0020.
- Spurious: iack rises with eligible = 0 → vector_valid stays 0, ipr_clr = 0 throughout; FSM returns to IDLE after iack falls.
- Simultaneous: in the ACK cycle for ch 5, isr_wr with isr_wdata = 16'hFFDF → isr[5] = 1 (set wins). Clearing vr_s afterwards → isr = 0 next cycle.
- Reset mid-HOLD: assert reset_n = 0 while vector_valid = 1 → vector_valid = 0, irq_n = 1, isr = 0 immediately; after release with iack still high, no ACK occurs until iack is seen low then rising.
